// File: rtl/multi_channel_interval_timer.sv
// Multi-channel interval timer: NUM_CHANNELS prescaled down-counters behind one
// Avalon-MM slave, with a shared interrupt and a global pending register.
module multi_channel_interval_timer #(
  parameter int          NUM_CHANNELS  = 4,
  parameter int          COUNTER_WIDTH = 32,
  parameter int          ADDR_WIDTH    = 5,
  parameter logic [31:0] RESET_PERIOD  = 32'h30D3F
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int CW   = COUNTER_WIDTH;
  localparam int CH_W = ADDR_WIDTH - 2;

  logic                    wr;
  logic [CH_W-1:0]         ch_sel;
  logic [1:0]              reg_sel;
  logic                    pend_hit;
  logic [NUM_CHANNELS-1:0] to_v;
  logic [NUM_CHANNELS-1:0] ito_v;
  logic [NUM_CHANNELS-1:0][31:0] ch_rd;
  logic [31:0]             readdata_d;
  logic [31:0]             readdata_q;
  logic                    unused_wd;

  assign wr        = chipselect & ~write_n;
  assign ch_sel    = address[ADDR_WIDTH-1:2];
  assign reg_sel   = address[1:0];
  assign pend_hit  = (address == ADDR_WIDTH'(4 * NUM_CHANNELS));
  assign unused_wd = ^writedata;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [CW-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
    logic [7:0]    psc_q, psc_d, prescale_q, prescale_d;
    logic          ito_q, ito_d, cont_q, cont_d, run_q, run_d, to_q, to_d;
    logic          sel, tick, timeout;
    logic [31:0]   word;

    assign sel     = (ch_sel == CH_W'(c));
    assign tick    = run_q && (psc_q == prescale_q);
    assign timeout = tick && (cnt_q == '0);

    always_comb begin
      period_d   = period_q;
      cnt_d      = cnt_q;
      snap_d     = snap_q;
      psc_d      = psc_q;
      prescale_d = prescale_q;
      ito_d      = ito_q;
      cont_d     = cont_q;
      run_d      = run_q;
      to_d       = to_q;

      if (run_q) psc_d = tick ? 8'd0 : psc_q + 8'd1;
      if (tick) cnt_d = timeout ? period_q : cnt_q - 1'b1;
      if (timeout && !cont_q) run_d = 1'b0;

      // Bus writes override counting, except that a fresh timeout beats a TO clear.
      if (wr && sel) begin
        case (reg_sel)
          2'd0: to_d = 1'b0;
          2'd1: begin
            ito_d      = writedata[0];
            cont_d     = writedata[1];
            prescale_d = writedata[15:8];
            if (writedata[3]) run_d = 1'b0;
            if (writedata[2]) begin
              run_d = 1'b1;
              psc_d = 8'd0;
            end
          end
          2'd2: begin
            period_d = writedata[CW-1:0];
            cnt_d    = writedata[CW-1:0];
            run_d    = 1'b0;
          end
          2'd3: snap_d = cnt_q;
        endcase
      end
      if (timeout) to_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        period_q   <= RESET_PERIOD[CW-1:0];
        cnt_q      <= RESET_PERIOD[CW-1:0];
        snap_q     <= '0;
        psc_q      <= 8'd0;
        prescale_q <= 8'd0;
        ito_q      <= 1'b0;
        cont_q     <= 1'b0;
        run_q      <= 1'b0;
        to_q       <= 1'b0;
      end else begin
        period_q   <= period_d;
        cnt_q      <= cnt_d;
        snap_q     <= snap_d;
        psc_q      <= psc_d;
        prescale_q <= prescale_d;
        ito_q      <= ito_d;
        cont_q     <= cont_d;
        run_q      <= run_d;
        to_q       <= to_d;
      end
    end

    always_comb begin
      word = '0;
      case (reg_sel)
        2'd0: word = {30'd0, run_q, to_q};
        2'd1: word = {16'd0, prescale_q, 6'd0, cont_q, ito_q};
        2'd2: word = 32'(period_q);
        2'd3: word = 32'(snap_q);
      endcase
    end

    assign ch_rd[c] = sel ? word : 32'd0;
    assign to_v[c]  = to_q;
    assign ito_v[c] = ito_q;
  end

  // Unselected channels contribute zero, so an OR forms the read mux.
  always_comb begin
    readdata_d = '0;
    if (pend_hit) begin
      readdata_d = 32'(to_v & ito_v);
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) readdata_d = readdata_d | ch_rd[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |(to_v & ito_v);

endmodule

// File: doc/multi_channel_interval_timer.md
# multi_channel_interval_timer

Parametrised, multi-channel successor to the node's single interval timer, used by each processing node to time compute phases and generate periodic ticks for several software tasks at once. It provides NUM_CHANNELS independent down-counters of COUNTER_WIDTH bits, each with:
- its own period and control;
- an 8-bit tick prescaler;
- a snapshot register.

All channels share one Avalon-MM slave and one interrupt line. A global pending register lets the interrupt handler identify the firing channels in a single read.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of timer channels (1..8)
- COUNTER_WIDTH, 32, counter/period width in bits (1..32)
- ADDR_WIDTH, 5, word address width; must satisfy 2^ADDR_WIDTH > 4*NUM_CHANNELS
- RESET_PERIOD, 32'h30D3F, period and counter value after reset, all channels

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- address  in  ADDR_WIDTH  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe (valid with chipselect)
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  OR over channels of (TO & ITO)

## Operation
Register map:
- Channel c occupies word addresses 4c..4c+3; the register index r is the low two address bits.
- r0 STATUS, read: bit0 TO, bit1 RUN. Any write clears TO.
- r1 CONTROL, read/write:
  - bit0 ITO (interrupt enable), bit1 CONT (continuous mode).
  - bits 15:8 PRESCALE.
  - bit2 START and bit3 STOP are write-only pulses; they are not stored and read as 0.
- r2 PERIOD: read/write, low COUNTER_WIDTH bits; upper bits read 0.
- r3 SNAP: a write captures the counter; a read returns the captured value.
- Address 4*NUM_CHANNELS is PENDING (read-only): bit c = TO_c & ITO_c.
- Unmapped addresses read 0; writes to them are ignored.

Counting:
- A tick fires for a running channel when its prescale counter equals PRESCALE; the prescale counter then returns to 0, otherwise it increments.
- On a tick, the counter decrements if nonzero.
- On a tick with counter == 0:
  - counter <= PERIOD and TO <= 1;
  - RUN <= 0 if CONT = 0.
- Consequence: one timeout every (PERIOD+1)*(PRESCALE+1) clocks.

Control actions:
- START: RUN <= 1 and prescale counter <= 0. The counter keeps its current value.
- STOP: RUN <= 0. Counter and prescale counter hold.
- START and STOP in the same write: START wins.
- PERIOD write: PERIOD updates, counter <= new value and RUN <= 0, all on the same edge.
- TO clear and a timeout event in the same cycle: TO = 1, so the new event is not lost.
- PERIOD = 0 with CONT = 1: TO asserts on every tick.

Reset (reset_n low at a rising edge):
- Every channel: PERIOD = counter = RESET_PERIOD[COUNTER_WIDTH-1:0]; CONTROL = 0; RUN = 0; TO = 0; SNAP = 0; prescale counter = 0.
- Outputs: readdata = 0, irq = 0.
- Reset wins over any coincident bus access. Mid-count reset returns all state to these values on that edge.

## Timing
- Write (chipselect & ~write_n) takes effect on the same rising edge; the new state is visible the next cycle.
- Read: readdata is valid the cycle after address is presented, so latency is 1. readdata updates every cycle from the current address, regardless of chipselect.
- SNAP captures the counter value before the update that same edge applies.
- irq is combinational from the TO and ITO registers, so it asserts the cycle after the TO-setting edge.
- START on edge N: the first tick is on edge N+1+PRESCALE.

## Test plan
- Reset defaults:
  - Stimulus: hold reset_n low 2 cycles, release, read ch0 PERIOD, STATUS and CONTROL.
  - Required: PERIOD = 0x30D3F, STATUS = 0, CONTROL = 0, irq = 0.
- One-shot:
  - Stimulus: ch1 PERIOD = 9, CONTROL = ITO|START, PRESCALE = 0.
  - Required: TO and irq assert exactly 10 clocks after START; RUN = 0 afterwards; counter holds 9.
  - Required: a STATUS write drops irq the next cycle.
- Continuous with prescale:
  - Stimulus: ch2 PERIOD = 3, PRESCALE = 4, CONT|START.
  - Required: timeouts every 20 clocks; RUN remains 1; PENDING = 0 because ITO = 0.
- Simultaneous events:
  - Stimulus: ch0 STATUS write on the same edge its timeout fires.
  - Required: TO stays 1.
  - Stimulus: START|STOP written together.
  - Required: RUN = 1.
- Period write mid-count:
  - Stimulus: ch3 running at counter = 100, write PERIOD = 50.
  - Required: RUN = 0, counter = 50; SNAP write then reads 50.
- Multi-channel irq:
  - Stimulus: ch0 and ch3 time out with ITO set.
  - Required: PENDING = 0x9, irq = 1.
  - Stimulus: clear ch0 only.
  - Required: PENDING = 0x8, irq stays 1.
  - Stimulus: clear ch3.
  - Required: irq = 0.
